// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, IF/ID capture, stall/redirect/halt handling and fetch counting.
// Revision 1.0
`default_nettype none

module instruction_fetch #(
  parameter int                   ADD_WIDTH   = 8,
  parameter int                   WIDTH       = 32,
  parameter logic [6:0]           HALT_OPCODE = 7'b1111111,
  parameter logic [ADD_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ADD_WIDTH-1:0] imem_add,
  input  logic [WIDTH-1:0]     imem_instruction,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [ADD_WIDTH-1:0] redirect_add,
  output logic                 if_id_valid,
  output logic [WIDTH-1:0]     if_id_instruction,
  output logic [ADD_WIDTH-1:0] if_id_pc,
  output logic                 halted,
  output logic [15:0]          fetch_count
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [ADD_WIDTH-1:0] PC_ONE = {{(ADD_WIDTH-1){1'b0}}, 1'b1};

  state_t               state;
  logic [ADD_WIDTH-1:0] pc;

  assign imem_add = pc;
  assign halted   = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc                <= RESET_PC;
      state             <= RUN;
      if_id_valid       <= 1'b0;
      if_id_instruction <= '0;
      if_id_pc          <= '0;
      fetch_count       <= 16'd0;
    end else if (redirect) begin
      // Wrong-path instruction is flushed; a pending halt is cancelled.
      pc          <= redirect_add;
      if_id_valid <= 1'b0;
      state       <= RUN;
    end else if (!stall) begin
      case (state)
        RUN: begin
          if_id_instruction <= imem_instruction;
          if_id_pc          <= pc;
          if_id_valid       <= 1'b1;
          if (fetch_count != 16'hFFFF) begin
            fetch_count <= fetch_count + 16'd1;
          end
          if (imem_instruction[6:0] == HALT_OPCODE) begin
            state <= HALT;
          end else begin
            pc <= pc + PC_ONE;
          end
        end
        HALT: begin
          if_id_valid <= 1'b0;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
